// File: rtl/fma_issue_arbiter_if.sv
// Issue/response bundle between the FPU issue logic, the FMA pipe and the arbiter.
// No storage of its own. The slave side is the arbiter; the master side is the environment.
interface fma_issue_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [32:0]      req0_a;
    logic [32:0]      req0_b;
    logic [32:0]      req0_c;
    logic [2:0]       req0_rm;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [32:0]      req1_a;
    logic [32:0]      req1_b;
    logic [32:0]      req1_c;
    logic [2:0]       req1_rm;
    logic [TAG_W-1:0] req1_tag;

    logic             pipe_validin;
    logic [1:0]       pipe_op;
    logic [32:0]      pipe_a;
    logic [32:0]      pipe_b;
    logic [32:0]      pipe_c;
    logic [2:0]       pipe_rm;
    logic [32:0]      pipe_out;
    logic [4:0]       pipe_flags;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [TAG_W-1:0] resp_tag;
    logic [32:0]      resp_out;
    logic [4:0]       resp_flags;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_c, req0_rm, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_c, req1_rm, req1_tag,
        input  req1_ready,
        input  pipe_validin, pipe_op, pipe_a, pipe_b, pipe_c, pipe_rm,
        output pipe_out, pipe_flags,
        input  resp_valid, resp_id, resp_tag, resp_out, resp_flags,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_c, req0_rm, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_c, req1_rm, req1_tag,
        output req1_ready,
        output pipe_validin, pipe_op, pipe_a, pipe_b, pipe_c, pipe_rm,
        input  pipe_out, pipe_flags,
        output resp_valid, resp_id, resp_tag, resp_out, resp_flags,
        input  resp_ready
    );
endinterface

// File: rtl/fma_issue_arbiter.sv
// Round-robin two-port issue arbiter for the 2-cycle FMA pipe, with a credit-protected response FIFO.
// Latency: accept in T, resp_valid in T+3; 1 op/cycle while credits remain.
// Backpressure: ready drops when FIFO occupancy plus in-flight ops reaches RESP_DEPTH; FMA_ARB_PERF_CNT_EN adds perf counters.
module fma_issue_arbiter #(
    parameter int RESP_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    fma_issue_arbiter_if.slave  bus
`ifdef FMA_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_stall
`endif
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(RESP_DEPTH);

    typedef struct packed {
        logic             vld;
        logic             id;
        logic [TAG_W-1:0] tag;
    } flight_t;

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [32:0]      out;
        logic [4:0]       flags;
    } resp_t;

    flight_t       stg0_q, stg0_d;
    flight_t       stg1_q, stg1_d;
    logic          last_q, last_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    resp_t         mem_q [RESP_DEPTH];

    logic [CW:0]   committed;
    logic          credit_ok;
    logic          any_vld;
    logic          grant_id;
    logic          accepted;
    logic          push;
    logic          pop;
    resp_t         push_dat;
    resp_t         head_dat;

    // Credits count only registered state, so resp_ready never reaches reqN_ready.
    always_comb begin
        committed = {1'b0, occ_q} + (CW+1)'(stg0_q.vld) + (CW+1)'(stg1_q.vld);
        credit_ok = committed < DEPTH_C;
        any_vld   = bus.req0_valid | bus.req1_valid;
        grant_id  = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
        accepted  = reset_n & credit_ok & any_vld;
        last_d    = accepted ? grant_id : last_q;

        stg0_d    = '{vld: accepted, id: grant_id, tag: grant_id ? bus.req1_tag : bus.req0_tag};
        stg1_d    = stg0_q;

        push      = stg1_q.vld;
        pop       = (occ_q != '0) & bus.resp_ready;
        push_dat  = '{id: stg1_q.id, tag: stg1_q.tag, out: bus.pipe_out, flags: bus.pipe_flags};

        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        occ_d     = occ_q + CW'(push) - CW'(pop);
        head_dat  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg0_q   <= '0;
            stg1_q   <= '0;
            last_q   <= 1'b1;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            stg0_q   <= stg0_d;
            stg1_q   <= stg1_d;
            last_q   <= last_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign bus.req0_ready   = accepted & ~grant_id;
    assign bus.req1_ready   = accepted & grant_id;
    assign bus.pipe_validin = accepted;
    assign bus.pipe_op      = grant_id ? bus.req1_op : bus.req0_op;
    assign bus.pipe_a       = grant_id ? bus.req1_a  : bus.req0_a;
    assign bus.pipe_b       = grant_id ? bus.req1_b  : bus.req0_b;
    assign bus.pipe_c       = grant_id ? bus.req1_c  : bus.req0_c;
    assign bus.pipe_rm      = grant_id ? bus.req1_rm : bus.req0_rm;

    assign bus.resp_valid   = occ_q != '0;
    assign bus.resp_id      = head_dat.id;
    assign bus.resp_tag     = head_dat.tag;
    assign bus.resp_out     = head_dat.out;
    assign bus.resp_flags   = head_dat.flags;

    // The pipe cannot stall, so a result arriving at a full FIFO would be lost.
    push_when_full_a: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && occ_q == CW'(RESP_DEPTH)));

`ifdef FMA_ARB_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        if (accepted && perf_issued_q != 32'hFFFF_FFFF) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if (any_vld && !accepted && perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Randomized scoreboard bench for fma_issue_arbiter with a stub 2-cycle FMA pipe.
`timescale 1ns/1ps
module tb_fma_issue_arbiter;
    localparam int D  = 4;
    localparam int TW = 4;
    localparam logic [32:0] ONE = 33'h080000000;
    localparam logic [32:0] TWO = 33'h080800000;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    fma_issue_arbiter_if #(.TAG_W(TW)) bus ();

`ifdef FMA_ARB_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    fma_issue_arbiter #(.RESP_DEPTH(D), .TAG_W(TW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FMA_ARB_PERF_CNT_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stub FMA: 1.0*1.0+1.0 gives recoded 2.0; anything else maps to an operand hash.
    function automatic logic [32:0] fn_out(input logic [1:0] op, input logic [32:0] a,
                                           input logic [32:0] b, input logic [32:0] c);
        if (op == 2'd0 && a == ONE && b == ONE && c == ONE) return TWO;
        return (a ^ {b[31:0], b[32]} ^ {c[0], c[32:1]}) + {31'd0, op};
    endfunction

    function automatic logic [4:0] fn_flags(input logic [1:0] op, input logic [32:0] a,
                                            input logic [32:0] b, input logic [2:0] rm);
        return {rm, op} ^ a[4:0] ^ b[9:5];
    endfunction

    logic [32:0] p1_out, p2_out;
    logic [4:0]  p1_fl, p2_fl;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p1_out <= '0; p2_out <= '0; p1_fl <= '0; p2_fl <= '0;
        end else begin
            p1_out <= fn_out(bus.pipe_op, bus.pipe_a, bus.pipe_b, bus.pipe_c);
            p1_fl  <= fn_flags(bus.pipe_op, bus.pipe_a, bus.pipe_b, bus.pipe_rm);
            p2_out <= p1_out;
            p2_fl  <= p1_fl;
        end
    end
    assign bus.pipe_out   = p2_out;
    assign bus.pipe_flags = p2_fl;

    // Reference model: credits = ops accepted minus ops popped in earlier cycles.
    typedef struct {
        int              acc_cyc;
        logic            id;
        logic [TW-1:0]   tag;
        logic [32:0]     out;
        logic [4:0]      flags;
    } exp_t;

    exp_t sb[$];
    int   outstanding = 0;
    bit   m_last      = 1'b1;
    bit   m_last_nx   = 1'b1;
    bit   acc_now     = 1'b0;
    bit   pop_now     = 1'b0;
    int   dut_acc     = 0;
    bit   dut_grants[$];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= 0;
            m_last      <= 1'b1;
        end else begin
            cyc         <= cyc + 1;
            outstanding <= outstanding + int'(acc_now) - int'(pop_now);
            if (acc_now) m_last <= m_last_nx;
        end
    end

    // Issue side: predict readies and push the expected response on every predicted accept.
    always @(negedge clock) begin
        bit   any_v;
        bit   gid;
        bit   e_acc;
        exp_t e;
        any_v = bus.req0_valid || bus.req1_valid;
        gid   = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        e_acc = reset_n && any_v && (outstanding < D);
        acc_now = e_acc;
        check("req0_ready", 64'(bus.req0_ready), 64'(e_acc && !gid));
        check("req1_ready", 64'(bus.req1_ready), 64'(e_acc && gid));
        check("pipe_validin", 64'(bus.pipe_validin), 64'(e_acc));
        if (bus.req0_valid && bus.req0_ready) begin dut_acc++; dut_grants.push_back(1'b0); end
        if (bus.req1_valid && bus.req1_ready) begin dut_acc++; dut_grants.push_back(1'b1); end
        if (e_acc) begin
            m_last_nx = gid;
            e.acc_cyc = cyc;
            e.id      = gid;
            if (gid) begin
                e.tag   = bus.req1_tag;
                e.out   = fn_out(bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_c);
                e.flags = fn_flags(bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_rm);
            end else begin
                e.tag   = bus.req0_tag;
                e.out   = fn_out(bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_c);
                e.flags = fn_flags(bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_rm);
            end
            sb.push_back(e);
        end
    end

    // Response side: head is visible 3 cycles after its accept, popped when the consumer is ready.
    always @(negedge clock) begin
        bit   ev;
        exp_t e;
        pop_now = 1'b0;
        if (!reset_n) sb.delete();
        ev = reset_n && sb.size() > 0 && (cyc - sb[0].acc_cyc >= 3);
        check("resp_valid", 64'(bus.resp_valid), 64'(ev));
        if (ev && bus.resp_ready) begin
            e = sb.pop_front();
            pop_now = 1'b1;
            check("resp_id", 64'(bus.resp_id), 64'(e.id));
            check("resp_tag", 64'(bus.resp_tag), 64'(e.tag));
            check("resp_out", 64'(bus.resp_out), 64'(e.out));
            check("resp_flags", 64'(bus.resp_flags), 64'(e.flags));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_req0(input bit v);
        bus.req0_valid = v;
        bus.req0_op    = 2'($urandom);
        bus.req0_a     = {1'($urandom), 32'($urandom)};
        bus.req0_b     = {1'($urandom), 32'($urandom)};
        bus.req0_c     = {1'($urandom), 32'($urandom)};
        bus.req0_rm    = 3'($urandom);
        bus.req0_tag   = TW'($urandom);
    endtask

    task automatic rand_req1(input bit v);
        bus.req1_valid = v;
        bus.req1_op    = 2'($urandom);
        bus.req1_a     = {1'($urandom), 32'($urandom)};
        bus.req1_b     = {1'($urandom), 32'($urandom)};
        bus.req1_c     = {1'($urandom), 32'($urandom)};
        bus.req1_rm    = 3'($urandom);
        bus.req1_tag   = TW'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        rand_req0(1'b0);
        rand_req1(1'b0);
        bus.resp_ready = 1'b1;
        while ((sb.size() != 0 || outstanding != 0 || bus.resp_valid) && n < 100) begin
            step();
            n++;
        end
        step();
        if (n >= 100) begin
            errors++;
            $display("FAIL %s: drain timeout, pending=%0d expected 0", name, sb.size());
        end
    endtask

    initial begin
        int a0;
        int lat;
        int seen;
        rand_req0(1'b1);
        rand_req1(1'b1);
        bus.resp_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) step();
        check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
        check("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
        check("rst_pipe_validin", 64'(bus.pipe_validin), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        rand_req0(1'b0);
        rand_req1(1'b0);
        reset_n = 1'b1;
        step();

        // Sustained contention: grants alternate starting with req0.
        dut_grants.delete();
        for (int i = 0; i < 8; i++) begin
            rand_req0(1'b1);
            rand_req1(1'b1);
            bus.req0_tag = TW'(i);
            bus.req1_tag = TW'(i + 8);
            step();
        end
        check("contention_grants", 64'(dut_grants.size()), 64'd8);
        for (int i = 0; i < 8 && i < dut_grants.size(); i++)
            check("contention_order", 64'(dut_grants[i]), 64'(i % 2));
        wait_drain("contention");

        // 1.0*1.0+1.0 on req0, tag 3.
        rand_req0(1'b1);
        bus.req0_op = 2'd0; bus.req0_a = ONE; bus.req0_b = ONE; bus.req0_c = ONE;
        bus.req0_rm = 3'd0; bus.req0_tag = TW'(3);
        @(negedge clock);
        check("dir_accept", 64'(bus.req0_ready), 64'd1);
        step();
        bus.req0_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (bus.resp_valid) begin lat = k; break; end
        end
        check("dir_latency", 64'(lat), 64'd3);
        check("dir_out", 64'(bus.resp_out), 64'(TWO));
        check("dir_flags", 64'(bus.resp_flags), 64'd0);
        check("dir_id", 64'(bus.resp_id), 64'd0);
        check("dir_tag", 64'(bus.resp_tag), 64'd3);
        wait_drain("directed");

        // Consumer stalled: exactly D accepts, then release.
        bus.resp_ready = 1'b0;
        a0 = dut_acc;
        for (int i = 0; i < 10; i++) begin rand_req0(1'b1); step(); end
        check("stall_accepts", 64'(dut_acc - a0), 64'(D));
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin rand_req0(1'b1); step(); end
        wait_drain("stall");

        // Two results parked, then sustained push/pop across pointer wrap.
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin rand_req0(1'b1); step(); end
        rand_req0(1'b0);
        repeat (4) step();
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin rand_req0(1'b1); step(); end
        wait_drain("wrap");

        // Random traffic with random consumer backpressure.
        for (int i = 0; i < 400; i++) begin
            rand_req0($urandom_range(0, 9) < 7);
            rand_req1($urandom_range(0, 9) < 7);
            bus.resp_ready = $urandom_range(0, 9) < 6;
            step();
        end
        wait_drain("random");

        // Reset mid-stream with one parked result and two ops in flight.
        bus.resp_ready = 1'b0;
        rand_req0(1'b1);
        step();
        rand_req0(1'b0);
        repeat (4) step();
        rand_req0(1'b1);
        step();
        rand_req0(1'b1);
        step();
        reset_n = 1'b0;
        rand_req1(1'b1);
        #1;
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("midrst_req0_ready", 64'(bus.req0_ready), 64'd0);
        check("midrst_req1_ready", 64'(bus.req1_ready), 64'd0);
        check("midrst_pipe_validin", 64'(bus.pipe_validin), 64'd0);
        repeat (2) step();
        rand_req0(1'b0);
        rand_req1(1'b0);
        bus.resp_ready = 1'b1;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clock);
            if (bus.resp_valid) seen++;
        end
        check("midrst_stale_resp", 64'(seen), 64'd0);
        step();
        rand_req0(1'b1);
        rand_req1(1'b1);
        @(negedge clock);
        check("midrst_first_grant0", 64'(bus.req0_ready), 64'd1);
        check("midrst_first_grant1", 64'(bus.req1_ready), 64'd0);
        wait_drain("midrst");

`ifdef FMA_ARB_PERF_CNT_EN
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin rand_req0(1'b1); step(); end
        wait_drain("perf_a");
        for (int i = 0; i < 6; i++) begin rand_req0(1'b1); step(); end
        wait_drain("perf_b");
        check("perf_issued", 64'(perf_issued), 64'd10);
        check("perf_stall", 64'(perf_stall), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fma_issue_arbiter.md
# fma_issue_arbiter

Two-port issue controller for the shared pipelined recoded-FP32 fused multiply-add unit (`MulAddRecFNPipe`, fixed 2-cycle latency, no stall input). It round-robins between two requesters and drives the pipe's issue ports. It tracks every in-flight operation's owner and tag in a shift register and captures results into a credit-protected response FIFO, so a result is never lost when the consumer stalls. It sits between the FPU issue logic and the FMA pipe instance.

## Interface
- `RESP_DEPTH`, 4, response FIFO entries; power of two, 2..16
- `TAG_W`, 4, width of requester-supplied tag
- `clock`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when valid&ready
- `reqN_op`  in  2  FMA op code, same encoding as pipe `io_op`
- `reqN_a`, `reqN_b`, `reqN_c`  in  33  recoded FP32 operands
- `reqN_rm`  in  3  rounding mode
- `reqN_tag`  in  TAG_W  opaque tag returned with result
- `pipe_validin`  out  1  to pipe `io_validin`
- `pipe_op`  out  2;  `pipe_a`, `pipe_b`, `pipe_c`  out  33;  `pipe_rm`  out  3  to pipe inputs
- `pipe_out`  in  33;  `pipe_flags`  in  5  from pipe `io_out` / `io_exceptionFlags`
- `resp_valid`  out  1  FIFO head valid
- `resp_ready`  in  1  consumer pops head when valid&ready
- `resp_id`  out  1  owning requester (0/1)
- `resp_tag`  out  TAG_W;  `resp_out`  out  33;  `resp_flags`  out  5

## Operation
- Credit check is `occ + inflight < RESP_DEPTH`.
  - `occ` is the registered FIFO count; `inflight` is the popcount of the 2-bit in-flight valid shift register.
  - Uses registered values only; a pop frees its credit the following cycle. There is no combinational path from `resp_ready` to `reqN_ready`.
- Arbitration is round-robin with a `last` pointer; `last` resets to 1, so req0 wins the first conflict.
  - Both requesters valid: grant `!last`.
  - Only one valid: grant it.
  - `last` updates only on an accepted grant.
- `reqN_ready = credit_ok & grantN`.
  - Ready is combinational from valids and registered state.
  - At most one ready per cycle.
- `pipe_validin = accepted`. Pipe data outputs mux from the granted requester; they are don't-care when idle and are driven from req0 then.
- In-flight shift register: stage0 ← {accepted, id, tag}; stage1 ← stage0. Shifts every cycle.
- When stage1 is valid, push {id, tag, `pipe_out`, `pipe_flags`} into the FIFO that cycle.
- Push and pop can occur in the same cycle; `occ` is unchanged.
- The credit rule guarantees no push when full. A push while full is an assertion failure.
- FIFO: circular buffer, log2(RESP_DEPTH)-bit read/write pointers wrapping modulo depth, plus an `occ` counter of 0..RESP_DEPTH.
- Reset, asserted asynchronously, including mid-operation:
  - Clears shift-register valids, `occ` and pointers; sets `last` = 1.
  - Outputs go to `resp_valid`=0, `reqN_ready`=0, `pipe_validin`=0.
  - Results of ops in flight at reset are discarded. The pipe is expected to be reset concurrently.

## Timing
- Accept in cycle T → `pipe_validin` high in T.
- Result on `pipe_out` in T+2, pushed at the end of T+2, `resp_valid` in T+3.
- Total latency is 3 cycles; throughput is 1 op/cycle while credits remain.
- Results return in issue order. FIFO order equals issue order.
- Back-to-back grants are allowed. Under sustained contention each requester gets 1 op per 2 cycles.
- With `resp_ready`=0 permanently, exactly RESP_DEPTH ops are accepted, then both readies stay low.

## Configuration
- `FMA_ARB_PERF_CNT_EN` defined:
  - Adds 32-bit outputs `perf_issued` (accepted ops) and `perf_stall` (cycles with any reqN_valid high but no accept).
  - Both counters reset to 0 and saturate at 32'hFFFFFFFF.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- req0 op=0, a=b=c=33'h080000000 (1.0), tag=3, resp_ready=1 → resp_valid exactly 3 cycles after accept, resp_out=33'h080800000 (2.0), flags=0, id=0, tag=3.
- req0 and req1 valid continuously for 8 cycles with distinct tags → grants alternate 0,1,0,1… starting with 0; responses arrive in the same order.
- resp_ready=0, req0 valid always → exactly 4 accepts (RESP_DEPTH=4), then ready low. Raise resp_ready → one pop per cycle, and ready returns the cycle after the first pop.
- Pop and push in the same cycle with occ=2 → occ stays 2, data order preserved across pointer wrap (≥6 ops).
- Assert reset_n=0 mid-stream with 2 ops in flight → outputs clear immediately; after release, no stale resp_valid, and the first conflict is granted to req0.
- With `FMA_ARB_PERF_CNT_EN`, 10 accepts plus 3 credit-blocked cycles → perf_issued=10, perf_stall=3.
